// File: rtl/spec_txn_buffer_if.sv
// AXI3 write-address and write-data channels (no B channel) shared by the
// master-side and slave-side ports of the transaction buffer.
interface spec_txn_buffer_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int USER_W = 2
);
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [USER_W-1:0]   awuser;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  modport master (output awvalid, awid, awaddr, awlen, awsize, awburst, awuser,
                  output wvalid, wid, wdata, wstrb, wlast,
                  input  awready, wready);
  modport slave  (input  awvalid, awid, awaddr, awlen, awsize, awburst, awuser,
                  input  wvalid, wid, wdata, wstrb, wlast,
                  output awready, wready);
endinterface

// File: rtl/spec_txn_buffer.sv
// Stores special (DIVERT) and ID-colliding (unlucky) AXI3 write bursts in
// arrival order and replays each complete burst as one AW plus its W beats.
module spec_txn_buffer #(
  parameter int                DEPTH       = 4,
  parameter int                ID_W        = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                USER_W      = 2,
  parameter int                MAX_BEATS   = 8,
  parameter logic [USER_W-1:0] DIVERT_CODE = USER_W'(1),
  parameter int                AFULL_TH    = 3,
  localparam int CW = $clog2(DEPTH+1),
  localparam int IW = $clog2(DEPTH),
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
  localparam int SW = DATA_W/8
) (
  input  logic          clk,
  input  logic          rst,
  spec_txn_buffer_if.slave  s,
  spec_txn_buffer_if.master m,
  input  logic          to_block,
  input  logic          proc_full,
  input  logic          proc_empty,
  input  logic          release_req,
  output logic          release_ack,
  output logic          unluck,
  output logic [CW-1:0] count,
  output logic          almost_full,
  output logic          len_err
);
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [USER_W-1:0] user;
  } aw_t;

  typedef struct packed {
    logic                               vld;
    logic                               done;
    logic                               unl;
    logic [7:0]                         cur;
    aw_t                                aw;
    logic [MAX_BEATS-1:0][DATA_W-1:0]   data;
    logic [MAX_BEATS-1:0][SW-1:0]       strb;
  } slot_t;

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W} st_t;

  // slot 0 is always the oldest entry; valid slots are kept contiguous
  slot_t          slot_q [DEPTH];
  slot_t          slot_w [DEPTH];
  slot_t          slot_n [DEPTH];
  slot_t          new_slot;
  st_t            st_q, st_n;
  logic [IW-1:0]  sel_q, wr_idx, cand_idx;
  logic [7:0]     beat_q;
  logic [CW-1:0]  count_q, put_pos;
  logic           id_hit, divert, full, adm, w_fire, wr_hit, cand_hit, rel_hit, free;

  assign divert      = s.awuser == DIVERT_CODE;
  assign full        = count_q == CW'(DEPTH);
  assign len_err     = s.awvalid & (({1'b0, s.awlen} + 9'd1) > 9'(MAX_BEATS));
  assign unluck      = s.awvalid & ~divert & id_hit;
  assign s.awready   = ~full & ~to_block & ~proc_full & ~proc_empty & ~len_err & (divert | id_hit);
  assign adm         = s.awvalid & s.awready;
  assign s.wready    = s.wvalid & wr_hit;
  assign w_fire      = s.wvalid & s.wready;
  assign count       = count_q;
  assign almost_full = count_q >= CW'(AFULL_TH);
  assign release_ack = rel_hit;
  assign free        = (st_q == ST_W) & m.wready & (beat_q == slot_q[sel_q].aw.len);
  assign put_pos     = free ? count_q - CW'(1) : count_q;

  always_comb begin
    id_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (slot_q[i].vld && slot_q[i].aw.id == s.awid) id_hit = 1'b1;
  end

  // oldest open slot with a matching ID takes the beat; the slot under replay is excluded
  always_comb begin
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (slot_q[i].vld && !slot_q[i].done && slot_q[i].aw.id == s.wid &&
          !(st_q != ST_IDLE && sel_q == IW'(i))) begin
        wr_hit = 1'b1;
        wr_idx = IW'(i);
      end
  end

  always_comb begin
    logic older;
    older    = 1'b0;
    cand_hit = 1'b0;
    cand_idx = '0;
    rel_hit  = 1'b0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      older = 1'b0;
      for (int j = 0; j < i; j++)
        if (slot_q[j].vld && slot_q[j].aw.id == slot_q[i].aw.id) older = 1'b1;
      if (slot_q[i].vld && slot_q[i].done && slot_q[i].unl && !older) begin
        cand_hit = 1'b1;
        cand_idx = IW'(i);
      end
    end
    if (!cand_hit && slot_q[0].vld && slot_q[0].done && release_req) begin
      cand_hit = 1'b1;
      rel_hit  = 1'b1;
    end
    if (st_q != ST_IDLE) begin
      cand_hit = 1'b0;
      rel_hit  = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_w[i] = slot_q[i];
    if (w_fire) begin
      if (slot_q[wr_idx].cur <= slot_q[wr_idx].aw.len) begin
        slot_w[wr_idx].data[slot_q[wr_idx].cur[BW-1:0]] = s.wdata;
        slot_w[wr_idx].strb[slot_q[wr_idx].cur[BW-1:0]] = s.wstrb;
      end
      if (slot_q[wr_idx].cur != 8'hFF) slot_w[wr_idx].cur = slot_q[wr_idx].cur + 8'd1;
      if (s.wlast) slot_w[wr_idx].done = 1'b1;
    end
  end

  always_comb begin
    new_slot          = '0;
    new_slot.vld      = 1'b1;
    new_slot.unl      = unluck;
    new_slot.aw.id    = s.awid;
    new_slot.aw.addr  = s.awaddr;
    new_slot.aw.len   = s.awlen;
    new_slot.aw.size  = s.awsize;
    new_slot.aw.burst = s.awburst;
    new_slot.aw.user  = s.awuser;
  end

  // compaction first, then the admitted descriptor lands behind the youngest survivor
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_n[i] = slot_w[i];
      if (free && IW'(i) >= sel_q)
        slot_n[i] = (i == DEPTH-1) ? '0 : slot_w[(i+1) % DEPTH];
      if (adm && CW'(i) == put_pos) slot_n[i] = new_slot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      count_q <= '0;
      sel_q   <= '0;
      beat_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_n[i];
      case ({adm, free})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (cand_hit) begin
        sel_q  <= cand_idx;
        beat_q <= '0;
      end else if (st_q == ST_W && m.wready) begin
        beat_q <= beat_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) st_q <= ST_IDLE;
    else     st_q <= st_n;
  end

  always_comb begin
    st_n = st_q;
    case (st_q)
      ST_IDLE: if (cand_hit) st_n = ST_AW;
      ST_AW:   if (m.awready) st_n = ST_W;
      ST_W:    if (free) st_n = ST_IDLE;
      default: st_n = ST_IDLE;
    endcase
  end

  always_comb begin
    m.awvalid = 1'b0;
    m.awid    = '0;
    m.awaddr  = '0;
    m.awlen   = '0;
    m.awsize  = '0;
    m.awburst = '0;
    m.awuser  = '0;
    m.wvalid  = 1'b0;
    m.wid     = '0;
    m.wdata   = '0;
    m.wstrb   = '0;
    m.wlast   = 1'b0;
    case (st_q)
      ST_AW: begin
        m.awvalid = 1'b1;
        m.awid    = slot_q[sel_q].aw.id;
        m.awaddr  = slot_q[sel_q].aw.addr;
        m.awlen   = slot_q[sel_q].aw.len;
        m.awsize  = slot_q[sel_q].aw.size;
        m.awburst = slot_q[sel_q].aw.burst;
        m.awuser  = slot_q[sel_q].aw.user;
      end
      ST_W: begin
        m.wvalid = 1'b1;
        m.wid    = slot_q[sel_q].aw.id;
        m.wdata  = slot_q[sel_q].data[beat_q[BW-1:0]];
        m.wstrb  = slot_q[sel_q].strb[beat_q[BW-1:0]];
        m.wlast  = beat_q == slot_q[sel_q].aw.len;
      end
      default: ;
    endcase
  end
endmodule
